// File: rtl/rmt_recovery_writer_if.sv
// Rename-map-table write sequencer bus: rename updates in, AMT read port, RMT write ports out.
// Optional recover_ident_i exists only when RMT_RECOV_IDENT_EN is defined.
interface rmt_recovery_writer_if #(
  parameter int SRAM_INDEX = 4,
  parameter int SRAM_WIDTH = 8
);
  logic                             recover_i;
`ifdef RMT_RECOV_IDENT_EN
  logic                             recover_ident_i;
`endif
  logic [3:0]                       rn_we_i;
  logic [3:0][SRAM_INDEX-1:0]       rn_addr_i;
  logic [3:0][SRAM_WIDTH-1:0]       rn_data_i;
  logic [3:0][SRAM_INDEX-1:0]       amt_addr_o;
  logic [3:0][SRAM_WIDTH-1:0]       amt_data_i;
  logic [3:0]                       we_o;
  logic [3:0][SRAM_INDEX-1:0]       addr_wr_o;
  logic [3:0][SRAM_WIDTH-1:0]       data_wr_o;
  logic                             busy_o;
  logic                             done_o;
  logic                             stall_o;

  modport slave (
`ifdef RMT_RECOV_IDENT_EN
    input  recover_ident_i,
`endif
    input  recover_i, rn_we_i, rn_addr_i, rn_data_i, amt_data_i,
    output amt_addr_o, we_o, addr_wr_o, data_wr_o, busy_o, done_o, stall_o
  );

  modport master (
`ifdef RMT_RECOV_IDENT_EN
    output recover_ident_i,
`endif
    output recover_i, rn_we_i, rn_addr_i, rn_data_i, amt_data_i,
    input  amt_addr_o, we_o, addr_wr_o, data_wr_o, busy_o, done_o, stall_o
  );
endinterface

// File: rtl/rmt_recovery_writer.sv
// RMT write sequencer: forwards rename writes, or copies the AMT into the RMT 4 entries/cycle on recovery.
// Define RMT_RECOV_IDENT_EN to add recover_ident_i (restore identity map instead of AMT contents).
module rmt_recovery_writer #(
  parameter int SRAM_DEPTH = 16,
  parameter int SRAM_INDEX = 4,
  parameter int SRAM_WIDTH = 8
) (
  input  logic                 clk,
  input  logic                 reset,
  rmt_recovery_writer_if.slave bus
);
  localparam int NUM_PORTS = 4;
  localparam logic [SRAM_INDEX-1:0] LAST_PTR = SRAM_INDEX'(SRAM_DEPTH - NUM_PORTS);
  localparam logic [SRAM_INDEX-1:0] PTR_STEP = SRAM_INDEX'(NUM_PORTS);

  typedef enum logic [1:0] {IDLE, COPY, DONE} state_t;

  state_t                                  r_state;
  logic [SRAM_INDEX-1:0]                   r_ptr;
  logic                                    r_busy;
  logic                                    r_done;
  logic [NUM_PORTS-1:0]                    r_we;
  logic [NUM_PORTS-1:0][SRAM_INDEX-1:0]    r_addr;
  logic [NUM_PORTS-1:0][SRAM_WIDTH-1:0]    r_data;
  logic [NUM_PORTS-1:0][SRAM_INDEX-1:0]    w_grp_addr;
  logic [NUM_PORTS-1:0][SRAM_WIDTH-1:0]    w_grp_data;
  logic                                    w_ident;

`ifdef RMT_RECOV_IDENT_EN
  logic r_ident;
  assign w_ident = r_ident;
`else
  assign w_ident = 1'b0;
`endif

  // Port k always owns entry ptr+k, so a recovery group never self-collides.
  for (genvar k = 0; k < NUM_PORTS; k++) begin : g_lane
    assign w_grp_addr[k] = r_ptr + SRAM_INDEX'(k);
    assign w_grp_data[k] = w_ident ? SRAM_WIDTH'(w_grp_addr[k]) : bus.amt_data_i[k];
  end

  assign bus.amt_addr_o = (r_state == COPY) ? w_grp_addr : '0;
  assign bus.we_o       = r_we;
  assign bus.addr_wr_o  = r_addr;
  assign bus.data_wr_o  = r_data;
  assign bus.busy_o     = r_busy;
  assign bus.done_o     = r_done;
  assign bus.stall_o    = r_busy | bus.recover_i;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= IDLE;
      r_ptr   <= '0;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
      r_we    <= '0;
      r_addr  <= '0;
      r_data  <= '0;
`ifdef RMT_RECOV_IDENT_EN
      r_ident <= 1'b0;
`endif
    end else begin
      r_done <= 1'b0;
`ifdef RMT_RECOV_IDENT_EN
      // Every recover_i is an entry or restart; mode is latched for the whole run.
      if (bus.recover_i) r_ident <= bus.recover_ident_i;
`endif
      case (r_state)
        IDLE: begin
          if (bus.recover_i) begin
            r_state <= COPY;
            r_ptr   <= '0;
            r_busy  <= 1'b1;
            r_we    <= '0;
          end else begin
            r_we   <= bus.rn_we_i;
            r_addr <= bus.rn_addr_i;
            r_data <= bus.rn_data_i;
          end
        end
        COPY: begin
          r_we   <= '1;
          r_addr <= w_grp_addr;
          r_data <= w_grp_data;
          // Restart takes priority over finishing; the group just read still issues.
          if (bus.recover_i) begin
            r_ptr <= '0;
          end else if (r_ptr == LAST_PTR) begin
            r_state <= DONE;
            r_done  <= 1'b1;
          end else begin
            r_ptr <= r_ptr + PTR_STEP;
          end
        end
        DONE: begin
          r_we  <= '0;
          r_ptr <= '0;
          if (bus.recover_i) begin
            r_state <= COPY;
          end else begin
            r_state <= IDLE;
            r_busy  <= 1'b0;
          end
        end
        default: begin
          r_state <= IDLE;
          r_busy  <= 1'b0;
          r_we    <= '0;
        end
      endcase
    end
  end
endmodule

// File: tb/tb_rmt_recovery_writer.sv
// Scoreboard bench for rmt_recovery_writer: directed stimulus schedules per-cycle expectations, negedge monitor checks.
module tb_rmt_recovery_writer;
  logic clk = 1'b0;
  logic reset = 1'b1;
  int   cyc = 0;
  int   checks = 0;
  int   errors = 0;
  bit   ident_mode = 1'b0;

  typedef struct {
    int              cyc;
    logic [3:0]      we;
    logic [3:0][3:0] addr;
    logic [3:0][7:0] data;
    logic            busy;
    logic            done;
    logic            stall;
    string           name;
  } exp_t;

  exp_t q[$];
  logic [7:0] amt_mem [16];

  rmt_recovery_writer_if #(.SRAM_INDEX(4), .SRAM_WIDTH(8)) bus ();

  rmt_recovery_writer #(.SRAM_DEPTH(16), .SRAM_INDEX(4), .SRAM_WIDTH(8)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Combinational AMT read model.
  always_comb begin
    for (int k = 0; k < 4; k++) bus.amt_data_i[k] = amt_mem[bus.amt_addr_o[k]];
  end

  always @(negedge clk) begin : monitor
    exp_t e;
    logic ok;
    while (q.size() > 0 && q[0].cyc <= cyc) begin
      e  = q.pop_front();
      ok = (e.cyc == cyc) && (bus.we_o === e.we) && (bus.busy_o === e.busy) &&
           (bus.done_o === e.done) && (bus.stall_o === e.stall);
      for (int k = 0; k < 4; k++)
        if (e.we[k] && ((bus.addr_wr_o[k] !== e.addr[k]) || (bus.data_wr_o[k] !== e.data[k]))) ok = 1'b0;
      checks++;
      if (!ok) begin
        errors++;
        $display("FAIL %s cyc=%0d(want %0d): got we=%b addr=%h data=%h busy=%b done=%b stall=%b; want we=%b addr=%h data=%h busy=%b done=%b stall=%b",
                 e.name, cyc, e.cyc, bus.we_o, bus.addr_wr_o, bus.data_wr_o, bus.busy_o, bus.done_o, bus.stall_o,
                 e.we, e.addr, e.data, e.busy, e.done, e.stall);
      end
    end
  end

  function automatic void push(int c, logic [3:0] we, logic [3:0][3:0] a, logic [3:0][7:0] d,
                               logic busy, logic done, logic stall, string nm);
    exp_t e;
    e.cyc = c; e.we = we; e.addr = a; e.data = d;
    e.busy = busy; e.done = done; e.stall = stall; e.name = nm;
    q.push_back(e);
  endfunction

  function automatic void push_idle(int c, logic busy, logic stall, string nm);
    push(c, 4'b0000, '0, '0, busy, 1'b0, stall, nm);
  endfunction

  // Recovery group starting at entry `base`: AMT[i] = 0x40+i, identity mode gives data = i.
  function automatic void grp(int c, int base, logic done, string nm);
    logic [3:0][3:0] a;
    logic [3:0][7:0] d;
    for (int k = 0; k < 4; k++) begin
      a[k] = 4'(base + k);
      d[k] = ident_mode ? 8'(base + k) : 8'(8'h40 + base + k);
    end
    push(c, 4'b1111, a, d, 1'b1, done, 1'b1, nm);
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    int c;
    logic [3:0][3:0] a;
    logic [3:0][7:0] d;
    for (int i = 0; i < 16; i++) amt_mem[i] = 8'(8'h40 + i);
    bus.recover_i = 1'b0;
`ifdef RMT_RECOV_IDENT_EN
    bus.recover_ident_i = 1'b0;
`endif
    bus.rn_we_i = '0; bus.rn_addr_i = '0; bus.rn_data_i = '0;

    // Reset held for two edges, then idle.
    tick(); c = cyc;
    push_idle(c, 0, 0, "rst1"); push_idle(c + 1, 0, 0, "rst2"); push_idle(c + 2, 0, 0, "rst_idle");
    tick(); reset = 1'b0;
    tick(); tick();

    // Single rename write on port 1.
    c = cyc;
    a = '0; d = '0; a[1] = 4'd5; d[1] = 8'h2A;
    push(c + 1, 4'b0010, a, d, 0, 0, 0, "rn_single");
    push_idle(c + 2, 0, 0, "rn_single_post");
    bus.rn_we_i = 4'b0010; bus.rn_addr_i = a; bus.rn_data_i = d;
    tick(); bus.rn_we_i = '0;
    tick(); tick();

    // Rename-path collision (ports 0 and 2 both address 7) forwarded unchanged.
    c = cyc;
    a[0] = 4'd7; a[1] = 4'd2; a[2] = 4'd7; a[3] = 4'd9;
    d[0] = 8'h11; d[1] = 8'h22; d[2] = 8'h33; d[3] = 8'h44;
    push(c + 1, 4'b1111, a, d, 0, 0, 0, "rn_collide");
    bus.rn_we_i = 4'b1111; bus.rn_addr_i = a; bus.rn_data_i = d;
    tick(); bus.rn_we_i = '0;
    tick(); tick();

    // Full recovery; rename write in the recover cycle and during the copy is dropped.
    c = cyc;
    push_idle(c, 0, 1, "rec_c0");
    push_idle(c + 1, 1, 1, "rec_c1_drop");
    grp(c + 2, 0, 0, "rec_g0"); grp(c + 3, 4, 0, "rec_g4");
    grp(c + 4, 8, 0, "rec_g8"); grp(c + 5, 12, 1, "rec_g12_done");
    push_idle(c + 6, 0, 0, "rec_after");
    bus.recover_i = 1'b1; bus.rn_we_i = 4'b0001; bus.rn_addr_i = '0; bus.rn_addr_i[0] = 4'd3;
    bus.rn_data_i = '0; bus.rn_data_i[0] = 8'h77;
    tick(); bus.recover_i = 1'b0; bus.rn_we_i = 4'b1111; bus.rn_data_i = {4{8'hEE}};
    repeat (5) tick();
    bus.rn_we_i = '0;
    tick(); tick();

    // Restart mid-copy at relative cycle 3.
    c = cyc;
    push_idle(c, 0, 1, "rs_c0"); push_idle(c + 1, 1, 1, "rs_c1");
    grp(c + 2, 0, 0, "rs_g0"); grp(c + 3, 4, 0, "rs_g4"); grp(c + 4, 8, 0, "rs_g8");
    grp(c + 5, 0, 0, "rs_g0b"); grp(c + 6, 4, 0, "rs_g4b"); grp(c + 7, 8, 0, "rs_g8b");
    grp(c + 8, 12, 1, "rs_g12_done"); push_idle(c + 9, 0, 0, "rs_after");
    bus.recover_i = 1'b1;
    tick(); bus.recover_i = 1'b0;
    tick(); tick(); bus.recover_i = 1'b1;
    tick(); bus.recover_i = 1'b0;
    repeat (7) tick();

    // Reset mid-recovery: no group after the reset edge.
    c = cyc;
    push_idle(c, 0, 1, "rr_c0"); push_idle(c + 1, 1, 1, "rr_c1");
    grp(c + 2, 0, 0, "rr_g0");
    push_idle(c + 3, 0, 0, "rr_reset"); push_idle(c + 4, 0, 0, "rr_idle");
    bus.recover_i = 1'b1;
    tick(); bus.recover_i = 1'b0;
    tick(); reset = 1'b1;
    tick(); reset = 1'b0;
    tick(); tick();

`ifdef RMT_RECOV_IDENT_EN
    // Identity restore ignores AMT contents.
    ident_mode = 1'b1;
    c = cyc;
    push_idle(c, 0, 1, "id_c0"); push_idle(c + 1, 1, 1, "id_c1");
    grp(c + 2, 0, 0, "id_g0"); grp(c + 3, 4, 0, "id_g4");
    grp(c + 4, 8, 0, "id_g8"); grp(c + 5, 12, 1, "id_g12");
    push_idle(c + 6, 0, 0, "id_after");
    bus.recover_i = 1'b1; bus.recover_ident_i = 1'b1;
    tick(); bus.recover_i = 1'b0; bus.recover_ident_i = 1'b0;
    repeat (7) tick();
`endif

    for (int n = 0; n < 50 && q.size() > 0; n++) tick();
    if (q.size() > 0) begin
      errors++;
      $display("FAIL drain: %0d expectations never checked, want 0", q.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
